// File: rtl/wb_sel_pkg.sv
// Shared types and defaults for the write-back data selector.
// Holds the skid-buffer state enum, the entry struct and default constants.
package wb_sel_pkg;

  localparam int unsigned CONST_VAL_DEF = 227;
  localparam int          CONST_IDX_DEF = 3;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_t;

  // Entry layout for the default widths; the
  // top re-declares it with its own widths.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [RD_W_DEF-1:0]   rd;
    logic                  err;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational write-back source selector with a constant slot.
// Ports: sel, in_data (flattened sources), rd -> data, err.
module wb_src_mux
  import wb_sel_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_SRC   = 8,
  parameter int          SEL_W     = $clog2(NUM_SRC),
  parameter int          CONST_IDX = CONST_IDX_DEF,
  parameter int unsigned CONST_VAL = CONST_VAL_DEF,
  parameter int          RD_W      = 5
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]           rd,
  output logic [DATA_W-1:0]         data,
  output logic                      err
);

  logic [DATA_W-1:0] raw;

  always_comb begin
    raw = '0;
    err = 1'b0;
    if (int'(sel) >= NUM_SRC) begin
      err = 1'b1;
    end else if (int'(sel) == CONST_IDX) begin
      raw = DATA_W'(CONST_VAL);
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (int'(sel) == i) begin
          raw = in_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // $0 is hard-wired to zero in the register file.
  assign data = (rd == '0) ? '0 : raw;

endmodule

// File: rtl/wb_data_sel.sv
// Write-back data selector feeding a 2-entry skid buffer.
// Ports: clk, reset, in_valid/in_ready/in_sel/in_data/in_rd,
// out_valid/out_ready/out_data/out_rd/out_err.
// Optional WB_DATA_SEL_STATS_EN adds stall_cnt and err_cnt.
module wb_data_sel
  import wb_sel_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_SRC   = 8,
  parameter int          SEL_W     = $clog2(NUM_SRC),
  parameter int          CONST_IDX = CONST_IDX_DEF,
  parameter int unsigned CONST_VAL = CONST_VAL_DEF,
  parameter int          RD_W      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]           in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [RD_W-1:0]           out_rd,
`ifdef WB_DATA_SEL_STATS_EN
  output logic [31:0]               stall_cnt,
  output logic [15:0]               err_cnt,
`endif
  output logic                      out_err
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RD_W-1:0]   rd;
    logic              err;
  } entry_t;

  wb_state_t state;
  wb_state_t state_nxt;

  entry_t head;
  entry_t skid;
  entry_t new_ent;

  logic [DATA_W-1:0] mux_data;
  logic              mux_err;
  logic              accept;
  logic              pop;

  wb_src_mux #(
    .DATA_W   (DATA_W),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .CONST_IDX(CONST_IDX),
    .CONST_VAL(CONST_VAL),
    .RD_W     (RD_W)
  ) u_mux (
    .sel    (in_sel),
    .in_data(in_data),
    .rd     (in_rd),
    .data   (mux_data),
    .err    (mux_err)
  );

  assign new_ent.data = mux_data;
  assign new_ent.rd   = in_rd;
  assign new_ent.err  = mux_err;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_EMPTY: begin
        if (accept) state_nxt = ST_ONE;
      end
      ST_ONE: begin
        if (accept && !pop) state_nxt = ST_FULL;
        else if (!accept && pop) state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (pop) state_nxt = ST_ONE;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake flags decode the state register only,
  // so nothing on in_* reaches them combinationally.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (1'b1)
      state == ST_ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      state == ST_FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      skid <= '0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) head <= new_ent;
        end
        ST_ONE: begin
          if (accept && pop) head <= new_ent;
          else if (accept) skid <= new_ent;
        end
        ST_FULL: begin
          if (pop) head <= skid;
        end
        default: ;
      endcase
    end
  end

  assign out_data = head.data;
  assign out_rd   = head.rd;
  assign out_err  = head.err;

`ifdef WB_DATA_SEL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (accept && mux_err && err_cnt != '1) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_data_sel.sv
// Directed self-checking bench for wb_data_sel.
// Covers select, $0, range error, backpressure, streaming, reset.
module tb_wb_data_sel;

  localparam int DW = 32;

  logic clk;
  logic reset;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_sel;
  logic [255:0]  in_data;
  logic [4:0]    in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [4:0]    out_rd;
  logic          out_err;

  logic          v6;
  logic          r6;
  logic [2:0]    sel6;
  logic [191:0]  data6;
  logic [4:0]    rd6;
  logic          ov6;
  logic          ordy6;
  logic [31:0]   od6;
  logic [4:0]    ord6;
  logic          oe6;

`ifdef WB_DATA_SEL_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] err_cnt;
  logic [31:0] stall6;
  logic [15:0] err6;
`endif

  int errors = 0;
  int checks = 0;

  wb_data_sel dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_rd   (out_rd),
`ifdef WB_DATA_SEL_STATS_EN
    .stall_cnt(stall_cnt),
    .err_cnt  (err_cnt),
`endif
    .out_err  (out_err)
  );

  wb_data_sel #(.NUM_SRC(6)) dut6 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (v6),
    .in_ready (r6),
    .in_sel   (sel6),
    .in_data  (data6),
    .in_rd    (rd6),
    .out_valid(ov6),
    .out_ready(ordy6),
    .out_data (od6),
    .out_rd   (ord6),
`ifdef WB_DATA_SEL_STATS_EN
    .stall_cnt(stall6),
    .err_cnt  (err6),
`endif
    .out_err  (oe6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_data got=%h exp=0", out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_select;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      in_data[i*DW +: DW] = 32'h1000_0000 + i;
    end
    out_ready = 1'b1;
    in_rd     = 5'd5;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel = 3'(i);
      exp    = (i == 3) ? 32'h0000_00E3 : 32'h1000_0000 + i;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        errors++;
        $display("FAIL sel%0d got=%h/%b exp=%h/1",
                 i, out_data, out_valid, exp);
      end
      checks++;
      if (out_rd !== 5'd5 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL sel%0d_rd got=%0d/%b exp=5/0",
                 i, out_rd, out_err);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rd0;
    in_data[31:0] = 32'hDEAD_BEEF;
    in_sel   = 3'd0;
    in_rd    = 5'd0;
    in_valid = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0) begin
      errors++;
      $display("FAIL rd0_data got=%h/%b exp=0/1",
               out_data, out_valid);
    end
    checks++;
    if (out_rd !== 5'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL rd0_rd got=%0d/%b exp=0/0", out_rd, out_err);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_range;
    for (int i = 0; i < 6; i++) begin
      data6[i*DW +: DW] = 32'h2000_0000 + i;
    end
    ordy6 = 1'b1;
    rd6   = 5'd7;
    sel6  = 3'd7;
    v6    = 1'b1;
    tick();
    checks++;
    if (ov6 !== 1'b1 || od6 !== 32'h0 || oe6 !== 1'b1) begin
      errors++;
      $display("FAIL oor got=%h/%b/%b exp=0/1/1", od6, ov6, oe6);
    end
    sel6 = 3'd5;
    tick();
    checks++;
    if (od6 !== 32'h2000_0005 || oe6 !== 1'b0) begin
      errors++;
      $display("FAIL inrange6 got=%h/%b exp=20000005/0", od6, oe6);
    end
`ifdef WB_DATA_SEL_STATS_EN
    checks++;
    if (err6 !== 16'd1) begin
      errors++;
      $display("FAIL err_cnt got=%0d exp=1", err6);
    end
`endif
    v6 = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    in_sel    = 3'd0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data[31:0] = 32'h11;
    in_rd = 5'd1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_a got=%h/%b exp=11/1", out_data, in_ready);
    end
    in_data[31:0] = 32'h22;
    in_rd = 5'd2;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_b got=%h/%b exp=11/0", out_data, in_ready);
    end
    in_data[31:0] = 32'h33;
    in_rd = 5'd3;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_data !== 32'h11 ||
        out_rd !== 5'd1) begin
      errors++;
      $display("FAIL bp_hold got=%h/%0d/%b exp=11/1/0",
               out_data, out_rd, in_ready);
    end
`ifdef WB_DATA_SEL_STATS_EN
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL stall_cnt got=%0d exp=2", stall_cnt);
    end
`endif
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 32'h22 || out_rd !== 5'd2 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rel_b got=%h/%0d/%b exp=22/2/1",
               out_data, out_rd, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h33 ||
        out_rd !== 5'd3) begin
      errors++;
      $display("FAIL bp_rel_c got=%h/%0d/%b exp=33/3/1",
               out_data, out_rd, out_valid);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got=%b exp=0", out_valid);
    end
`ifdef WB_DATA_SEL_STATS_EN
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL stall_end got=%0d exp=2", stall_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    in_sel    = 3'd0;
    in_rd     = 5'd9;
    in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data[31:0] = 32'h100 + k;
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 ||
          out_data !== 32'h100 + k) begin
        errors++;
        $display("FAIL stream%0d got=%h/%b/%b exp=%h/1/1",
                 k, out_data, out_valid, in_ready, 32'h100 + k);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data[31:0] = 32'hAA;
    tick();
    in_data[31:0] = 32'hBB;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_full got=%b exp=0", in_ready);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got=%b/%b exp=0/1",
               out_valid, in_ready);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost%0d got=%b/%h exp=0",
                 k, out_valid, out_data);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    in_rd     = '0;
    out_ready = 1'b0;
    v6        = 1'b0;
    sel6      = '0;
    data6     = '0;
    rd6       = '0;
    ordy6     = 1'b1;
    test_reset();
    test_select();
    test_rd0();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_data_sel.md
Name: wb_data_sel

Overview:
- Parametrised successor to the fixed 8:1 register-file write-data selector.
- Selects one of NUM_SRC write-back sources. Any one source index can be replaced by a hard-wired constant; the default is 227 at index 3.
- Registers the selected word with its destination register number into a 2-entry skid buffer with valid/ready handshakes.
- Sits between the datapath result sources (ALUOut, HI/LO, shifter, extenders, SetSize) and the register-file write port, so the control unit can stall write-back without losing results.

Parameters:
- DATA_W, 32, width of each source word and of out_data.
- NUM_SRC, 8, number of selectable sources (2..16).
- SEL_W, $clog2(NUM_SRC), select width (derived; do not override).
- CONST_IDX, 3, source index replaced by CONST_VAL; the in_data slice at this index is ignored.
- CONST_VAL, 227, constant driven when in_sel == CONST_IDX.
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  write-back request present.
- in_ready  out  1  block can accept a request this cycle.
- in_sel  in  SEL_W  source index.
- in_data  in  NUM_SRC*DATA_W  flattened sources; source i occupies bits [i*DATA_W +: DATA_W].
- in_rd  in  RD_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file consumes the head entry.
- out_data  out  DATA_W  selected word.
- out_rd  out  RD_W  destination register of the head entry.
- out_err  out  1  head entry had in_sel >= NUM_SRC.

Behaviour:
- Reset (synchronous, active-high):
  - state EMPTY, out_valid 0, out_data 0, out_rd 0, out_err 0, in_ready 1.
  - Reset asserted mid-operation discards all buffered entries on that edge.
- Select (combinational, evaluated at the accept cycle):
  - in_sel == CONST_IDX: CONST_VAL zero-extended to DATA_W.
  - in_sel < NUM_SRC otherwise: source in_sel.
  - in_sel >= NUM_SRC: data 0, err 1.
  - in_rd == 0: data forced to 0 (register $0 is never written non-zero); err is unaffected.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready is a registered signal: 1 in EMPTY and ONE, 0 in FULL.
  - out_valid is 1 in ONE and FULL.
- Latency: an accepted entry appears on out_* on the next cycle, registered outputs only. There is no combinational path from in_* to out_*.
- State machine (head register H, skid register S):
  - EMPTY, accept → ONE; H ← new entry.
  - ONE, accept without pop → FULL; S ← new entry.
  - ONE, pop without accept → EMPTY.
  - ONE, accept and pop → ONE; H ← new entry.
  - FULL, pop → ONE; H ← S. No accept is possible in FULL.
  - Any other combination holds the current state.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Held outputs: out_data, out_rd and out_err hold their values while out_valid && !out_ready.
- Idle outputs: when out_valid is 0, out_data, out_rd and out_err keep their last value; the consumer must ignore them.

Optional Feature:
- Macro WB_DATA_SEL_STATS_EN.
- Defined:
  - Adds outputs stall_cnt [31:0] and err_cnt [15:0], both reset to 0.
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - err_cnt increments on each accepted entry with err = 1.
  - Both counters saturate at all-ones and never wrap.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package wb_sel_pkg holds:
  - the state enum {ST_EMPTY, ST_ONE, ST_FULL};
  - the entry struct {data, rd, err};
  - localparam default values for CONST_VAL and CONST_IDX.
- One sub-module, wb_src_mux: the purely combinational parametrised selector (NUM_SRC, CONST_IDX, CONST_VAL, $0 forcing, err flag).
- wb_data_sel instantiates wb_src_mux and contains the skid buffer and state machine.

Test Plan:
1. Reset, then select each source: reset held 2 cycles → out_valid 0, in_ready 1, out_data 0. Then in_sel = 0..7 with source i = 0x1000_0000+i, rd 5, out_ready 1 → one cycle later out_data = 0x1000_0000+i for i ≠ 3, and 0x0000_00E3 for i = 3.
2. Register $0: in_rd 0, in_sel 0, source 0 = 0xDEADBEEF → out_data 0, out_rd 0, out_err 0.
3. Out-of-range select: NUM_SRC = 6 build, in_sel 7 → out_data 0, out_err 1. With WB_DATA_SEL_STATS_EN defined, err_cnt reads 1.
4. Backpressure:
   - out_ready 0; push A = 0x11, then B = 0x22 → in_ready drops to 0 the cycle after B is accepted, and C is not accepted.
   - Release out_ready → outputs A, then B, then C in order, with no loss.
   - stall_cnt equals the number of stalled cycles.
5. Simultaneous accept and pop in ONE: streaming 10 entries at full rate with out_ready 1 → in_ready stays 1, and each entry appears exactly 1 cycle after it is accepted.
6. Reset mid-operation: assert reset while FULL with 2 entries → next cycle out_valid 0 and in_ready 1; the old entries never appear.
